// File: rtl/mac_pipe_param.sv
// mac_pipe_param: pipelined signed multiply-accumulate with overflow flag and term counter; define MAC_SATURATE_EN to clamp f instead of wrapping
module mac_pipe_param #(
   parameter int A_W         = 12,
   parameter int B_W         = 12,
   parameter int ACC_W       = 24,
   parameter int MULT_STAGES = 3,
   parameter int CNT_W       = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_in,
   input  logic                    clear_in,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   output logic signed [ACC_W-1:0] f,
   output logic                    valid_out,
   output logic                    ovf,
   output logic [CNT_W-1:0]        term_cnt
);
   localparam int P_W = A_W + B_W;
   localparam int S_W = ACC_W + 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [A_W-1:0]   a_q, a_d;
   logic signed [B_W-1:0]   b_q, b_d;
   logic [MULT_STAGES:0]    v_q, v_d, c_q, c_d;
   logic signed [P_W-1:0]   p_q [MULT_STAGES];
   logic signed [P_W-1:0]   p_d [MULT_STAGES];
   logic signed [ACC_W-1:0] f_q, f_d, base, f_nx;
   logic signed [S_W-1:0]   sum;
   logic                    ovf_q, ovf_d, vo_q, vo_d, over;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   always_comb begin
      a_d = valid_in ? a : a_q;
      b_d = valid_in ? b : b_q;
      v_d = {v_q[MULT_STAGES-1:0], valid_in};
      c_d = {c_q[MULT_STAGES-1:0], valid_in & clear_in};
      p_d[0] = P_W'(a_q) * P_W'(b_q);
      for (int i = 1; i < MULT_STAGES; i++) p_d[i] = p_q[i-1];
      // sum is one bit wider than the accumulator so the sign bits expose overflow
      base = c_q[MULT_STAGES] ? '0 : f_q;
      sum  = S_W'(base) + S_W'(p_q[MULT_STAGES-1]);
      over = sum[S_W-1] != sum[S_W-2];
`ifdef MAC_SATURATE_EN
      f_nx = over ? (sum[S_W-1] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
`else
      f_nx = sum[ACC_W-1:0];
`endif
      f_d   = v_q[MULT_STAGES] ? f_nx : f_q;
      ovf_d = v_q[MULT_STAGES] ? over : ovf_q;
      vo_d  = v_q[MULT_STAGES];
      cnt_d = !v_q[MULT_STAGES] ? cnt_q : c_q[MULT_STAGES] ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q   <= '0;
         b_q   <= '0;
         v_q   <= '0;
         c_q   <= '0;
         for (int i = 0; i < MULT_STAGES; i++) p_q[i] <= '0;
         f_q   <= '0;
         ovf_q <= 1'b0;
         vo_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         v_q   <= v_d;
         c_q   <= c_d;
         for (int i = 0; i < MULT_STAGES; i++) p_q[i] <= p_d[i];
         f_q   <= f_d;
         ovf_q <= ovf_d;
         vo_q  <= vo_d;
         cnt_q <= cnt_d;
      end
   end
   assign f         = f_q;
   assign valid_out = vo_q;
   assign ovf       = ovf_q;
   assign term_cnt  = cnt_q;
endmodule

// File: tb/tb_mac_pipe_param.sv
// tb_mac_pipe_param: directed bench for mac_pipe_param with a sequential arithmetic reference model
module tb_mac_pipe_param;
   localparam int A_W = 12, B_W = 12, ACC_W = 24, MS = 3, CNT_W = 8;
   localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint MINV = -(longint'(1) << (ACC_W-1));
   localparam longint MODV = longint'(1) << ACC_W;
   logic clk = 0, reset = 1, valid_in = 0, clear_in = 0;
   logic signed [A_W-1:0] a = '0;
   logic signed [B_W-1:0] b = '0;
   logic signed [ACC_W-1:0] f;
   logic valid_out, ovf;
   logic [CNT_W-1:0] term_cnt;
   int checks = 0, errors = 0, cyc = 0, cap = 0;
   typedef struct {int due; longint f; bit o; int n;} exp_t;
   typedef struct {longint f; bit o; int n; int c;} ob_t;
   exp_t q[$];
   ob_t obs[$];
   longint m_f = 0, s = 0, e_f = 0;
   int m_n = 0, e_n = 0;
   bit m_o = 0, e_v = 0, e_o = 0;

   mac_pipe_param #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .MULT_STAGES(MS), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .clear_in(clear_in), .a(a), .b(b),
      .f(f), .valid_out(valid_out), .ovf(ovf), .term_cnt(term_cnt));

   always #5 clk = ~clk;

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: each accepted sample is folded into a running integer sum and scheduled MS+1 edges later
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q.delete();
         m_f = 0; m_n = 0; m_o = 0;
         e_v = 0; e_f = 0; e_o = 0; e_n = 0;
      end else begin
         cyc++;
         e_v = 0;
         if (q.size() > 0 && q[0].due == cyc) begin
            e_v = 1; e_f = q[0].f; e_o = q[0].o; e_n = q[0].n;
            void'(q.pop_front());
         end
         if (valid_in) begin
            s = (clear_in ? 0 : m_f) + longint'(a) * longint'(b);
            m_o = (s > MAXV) || (s < MINV);
`ifdef MAC_SATURATE_EN
            m_f = s > MAXV ? MAXV : s < MINV ? MINV : s;
`else
            m_f = s > MAXV ? s - MODV : s < MINV ? s + MODV : s;
`endif
            m_n = clear_in ? 1 : (m_n == (1 << CNT_W) - 1 ? m_n : m_n + 1);
            q.push_back('{cyc + MS + 1, m_f, m_o, m_n});
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("valid_out", valid_out, e_v);
         chk("f", f, e_f);
         chk("ovf", ovf, e_o);
         chk("term_cnt", term_cnt, e_n);
         if (valid_out) obs.push_back('{f, ovf, term_cnt, cyc});
      end
   end

   task automatic send(bit v, bit c, int av, int bv);
      @(negedge clk);
      valid_in = v; clear_in = c; a = A_W'(av); b = B_W'(bv);
   endtask

   task automatic idle(int n);
      repeat (n) send(0, 0, 0, 0);
   endtask

   task automatic lit(string nm, int i, longint fv, int nv, bit ov);
      if (i >= obs.size()) begin
         checks++; errors++;
         $display("FAIL %s: got no result %0d expected f=%0d", nm, i, fv);
      end else begin
         chk({nm, "_f"}, obs[i].f, fv);
         chk({nm, "_cnt"}, obs[i].n, nv);
         chk({nm, "_ovf"}, obs[i].o, ov);
      end
   endtask

   initial begin
      #1 reset = 0;
      repeat (2) @(negedge clk);
      chk("rst_f", f, 0); chk("rst_vo", valid_out, 0); chk("rst_ovf", ovf, 0); chk("rst_cnt", term_cnt, 0);
      reset = 1;
      // first sample without clear accumulates onto zero
      obs.delete();
      send(1, 0, 5, -3);
      idle(6);
      chk("t0_n", obs.size(), 1);
      lit("t0", 0, -15, 1, 0);
      // back-to-back burst then clear without bubble
      obs.delete();
      send(1, 1, 1, 2);
      cap = cyc + 1;
      for (int i = 2; i <= 5; i++) send(1, 0, i, 2);
      send(1, 1, 3, 4);
      idle(8);
      chk("t1_n", obs.size(), 6);
      chk("t1_lat", obs.size() > 0 ? obs[0].c - cap : -1, 4);
      chk("t1_span", obs.size() == 6 ? obs[5].c - obs[0].c : -1, 5);
      lit("t1a", 0, 2, 1, 0);
      lit("t1b", 1, 6, 2, 0);
      lit("t1c", 2, 12, 3, 0);
      lit("t1d", 3, 20, 4, 0);
      lit("t1e", 4, 30, 5, 0);
      lit("t2", 5, 12, 1, 0);
      // positive overflow
      obs.delete();
      send(1, 1, 2047, 2047); send(1, 0, 2047, 2047); send(1, 0, 2047, 2047);
      idle(8);
      lit("t3a", 0, 4190209, 1, 0);
      lit("t3b", 1, 8380418, 2, 0);
`ifdef MAC_SATURATE_EN
      lit("t3c", 2, 8388607, 3, 1);
`else
      lit("t3c", 2, -4206589, 3, 1);
`endif
      // negative overflow
      obs.delete();
      send(1, 1, -2048, 2047); send(1, 0, -2048, 2047); send(1, 0, -2048, 2047);
      idle(8);
      lit("t4a", 0, -4192256, 1, 0);
      lit("t4b", 1, -8384512, 2, 0);
`ifdef MAC_SATURATE_EN
      lit("t4c", 2, -8388608, 3, 1);
`else
      lit("t4c", 2, 4200448, 3, 1);
`endif
      // bubbles
      obs.delete();
      send(1, 1, 1, 1); send(0, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 1, 1);
      idle(8);
      chk("t5_n", obs.size(), 2);
      chk("t5_gap", obs.size() == 2 ? obs[1].c - obs[0].c : -1, 3);
      lit("t5a", 0, 1, 1, 0);
      lit("t5b", 1, 2, 2, 0);
      // term counter saturation
      obs.delete();
      send(1, 1, 1, 1);
      repeat (259) send(1, 0, 1, 1);
      idle(8);
      chk("tc_n", obs.size(), 260);
      lit("tc254", 254, 255, 255, 0);
      lit("tc259", 259, 260, 255, 0);
      // asynchronous reset with samples in flight
      send(1, 1, 7, 7); send(1, 0, 1, 1); send(1, 0, 1, 1);
      @(negedge clk);
      valid_in = 0;
      #2 reset = 0;
      #1;
      chk("t6_f", f, 0); chk("t6_vo", valid_out, 0); chk("t6_ovf", ovf, 0); chk("t6_cnt", term_cnt, 0);
      obs.delete();
      repeat (2) @(negedge clk);
      reset = 1;
      idle(6);
      chk("t6_nov", obs.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
